// File: rtl/store_buffer_pkg.sv
// rtl/store_buffer_pkg.sv - shared defaults and address constants for the store buffer
package store_buffer_pkg;

  localparam int SB_DEPTH = 4;
  localparam int SB_AW    = 32;
  localparam int SB_DW    = 32;

  // Byte offset bits below the word address; loads and stores match on the word only.
  localparam int WORD_LSB = 2;

  typedef enum logic [1:0] {
    SB_OP_IDLE = 2'b00,
    SB_OP_ENQ  = 2'b10,
    SB_OP_DEQ  = 2'b01,
    SB_OP_BOTH = 2'b11
  } sb_op_e;

endpackage

// File: rtl/sb_fwd_match.sv
// rtl/sb_fwd_match.sv - youngest-first address match over the buffered stores
module sb_fwd_match
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int WAW   = SB_AW - WORD_LSB,
  parameter int DW    = SB_DW
) (
  input  logic [DEPTH-1:0]              valid_i,
  input  logic [DEPTH-1:0][WAW-1:0]     waddr_i,
  input  logic [DEPTH-1:0][DW-1:0]      data_i,
  input  logic [$clog2(DEPTH)-1:0]      wr_ptr_i,
  input  logic [WAW-1:0]                lookup_i,
  output logic                          hit_o,
  output logic [DW-1:0]                 data_o
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] idx;
  logic          found;

  // Walk entries from the most recently written (wr_ptr-1) backwards; first valid match wins.
  always_comb begin
    found  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      idx = wr_ptr_i - PW'(k);
      if (!found && valid_i[idx] && (waddr_i[idx] == lookup_i)) begin
        found  = 1'b1;
        data_o = data_i[idx];
      end
    end
    hit_o = found;
  end

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - posted-write FIFO between core data port and memory, with load forwarding
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = SB_AW,
  parameter int DW    = SB_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          memwrite,
  input  logic [AW-1:0] dataadr,
  input  logic [DW-1:0] writedata,
  output logic          stall,
  output logic          fwd_hit,
  output logic [DW-1:0] fwd_data,
  output logic          mem_valid,
  input  logic          mem_ready,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          empty
);

  localparam int PW  = $clog2(DEPTH);
  localparam int WAW = AW - WORD_LSB;

  logic [PW-1:0]              wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]              rd_ptr_q, rd_ptr_d;
  logic [PW:0]                count_q, count_d;
  logic [DEPTH-1:0]           valid_q, valid_d;
  logic [DEPTH-1:0][WAW-1:0]  waddr_q;
  logic [DEPTH-1:0][DW-1:0]   data_q;

  logic   full;
  logic   enq;
  logic   deq;
  sb_op_e op;
  logic   unused_byte_offset;

  // Byte offset within the word plays no part in storage or matching.
  assign unused_byte_offset = ^dataadr[WORD_LSB-1:0];

  // A dequeue in the same cycle does not free a slot for a store arriving while full.
  assign full      = (count_q == (PW+1)'(DEPTH));
  assign stall     = memwrite && full;
  assign enq       = memwrite && !full;
  assign mem_valid = (count_q != '0);
  assign deq       = mem_valid && mem_ready;
  assign empty     = !mem_valid;
  assign op        = sb_op_e'({enq, deq});

  assign mem_addr  = {waddr_q[rd_ptr_q], {WORD_LSB{1'b0}}};
  assign mem_wdata = data_q[rd_ptr_q];

  // Pointer, occupancy and valid-bit next state from the enqueue/dequeue pair.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    valid_d  = valid_q;
    if (enq) begin
      wr_ptr_d          = wr_ptr_q + 1'b1;
      valid_d[wr_ptr_q] = 1'b1;
    end
    if (deq) begin
      rd_ptr_d          = rd_ptr_q + 1'b1;
      valid_d[rd_ptr_q] = 1'b0;
    end
    case (op)
      SB_OP_ENQ: count_d = count_q + 1'b1;
      SB_OP_DEQ: count_d = count_q - 1'b1;
      default:   count_d = count_q;
    endcase
  end

  // Control state; reset discards every pending store at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  // Entry payload is only meaningful under its valid bit, so it carries no reset.
  always_ff @(posedge clk) begin
    if (enq) begin
      waddr_q[wr_ptr_q] <= dataadr[AW-1:WORD_LSB];
      data_q[wr_ptr_q]  <= writedata;
    end
  end

  sb_fwd_match #(
    .DEPTH (DEPTH),
    .WAW   (WAW),
    .DW    (DW)
  ) u_fwd_match (
    .valid_i  (valid_q),
    .waddr_i  (waddr_q),
    .data_i   (data_q),
    .wr_ptr_i (wr_ptr_q),
    .lookup_i (dataadr[AW-1:WORD_LSB]),
    .hit_o    (fwd_hit),
    .data_o   (fwd_data)
  );

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - scoreboard bench for store_buffer
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic        stall;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        empty;

  int total = 0;
  int bad   = 0;

  logic [31:0] qa[$];
  logic [31:0] qd[$];

  store_buffer dut (
    .clk       (clk),
    .reset     (reset),
    .memwrite  (memwrite),
    .dataadr   (dataadr),
    .writedata (writedata),
    .stall     (stall),
    .fwd_hit   (fwd_hit),
    .fwd_data  (fwd_data),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .empty     (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: queue of pending stores, evaluated at the negedge before each active edge.
  always @(negedge clk) begin
    logic        exp_valid, do_enq, do_deq, mhit;
    logic [31:0] mdata;
    if (reset) begin
      qa.delete();
      qd.delete();
      check("rst_mem_valid", {31'b0, mem_valid}, 32'd0);
      check("rst_empty", {31'b0, empty}, 32'd1);
      check("rst_stall", {31'b0, stall}, 32'd0);
      check("rst_fwd_hit", {31'b0, fwd_hit}, 32'd0);
    end else begin
      exp_valid = (qa.size() != 0);
      do_enq    = memwrite && (qa.size() < DEPTH);
      do_deq    = exp_valid && mem_ready;
      check("mem_valid", {31'b0, mem_valid}, {31'b0, exp_valid});
      check("empty", {31'b0, empty}, {31'b0, !exp_valid});
      check("stall", {31'b0, stall}, {31'b0, memwrite && (qa.size() == DEPTH)});
      mhit  = 1'b0;
      mdata = 32'd0;
      for (int i = qa.size() - 1; i >= 0; i--) begin
        if (!mhit && (qa[i][31:2] == dataadr[31:2])) begin
          mhit  = 1'b1;
          mdata = qd[i];
        end
      end
      check("fwd_hit", {31'b0, fwd_hit}, {31'b0, mhit});
      check("fwd_data", fwd_data, mdata);
      if (do_deq) begin
        check("mem_addr", mem_addr, qa[0]);
        check("mem_wdata", mem_wdata, qd[0]);
        void'(qa.pop_front());
        void'(qd.pop_front());
      end
      if (do_enq) begin
        qa.push_back({dataadr[31:2], 2'b00});
        qd.push_back(writedata);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d);
    int   n;
    logic st;
    n         = 0;
    memwrite  = 1'b1;
    dataadr   = a;
    writedata = d;
    do begin
      @(negedge clk);
      st = stall;
      @(posedge clk);
      #1;
      n++;
    end while (st && n < 20);
    if (st) check("store_timeout", {31'b0, st}, 32'd0);
    memwrite = 1'b0;
  endtask

  task automatic wait_empty();
    int   n;
    logic e;
    n = 0;
    e = 1'b0;
    while (!e && n < 40) begin
      @(negedge clk);
      e = empty;
      n++;
    end
    if (!e) check("drain_timeout", {31'b0, e}, 32'd1);
    tick();
  endtask

  initial begin
    reset     = 1'b1;
    memwrite  = 1'b0;
    dataadr   = 32'd0;
    writedata = 32'd0;
    mem_ready = 1'b0;
    #10;
    check("t1_empty", {31'b0, empty}, 32'd1);
    check("t1_mem_valid", {31'b0, mem_valid}, 32'd0);
    check("t1_stall", {31'b0, stall}, 32'd0);
    #12;
    reset     = 1'b0;
    mem_ready = 1'b1;
    repeat (3) tick();
    check("t1_idle_valid", {31'b0, mem_valid}, 32'd0);

    // Test 2: single store drains with latency one.
    do_store(32'd84, 32'd7);
    check("t2_mem_valid", {31'b0, mem_valid}, 32'd1);
    check("t2_mem_addr", mem_addr, 32'd84);
    check("t2_mem_wdata", mem_wdata, 32'd7);
    tick();
    check("t2_empty", {31'b0, empty}, 32'd1);

    // Test 3: fill with memory stalled, fifth store waits for a free slot.
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) do_store(32'd80 + 32'(4 * i), 32'(i + 1));
    fork
      do_store(32'd96, 32'd5);
      begin
        repeat (2) @(posedge clk);
        #1;
        mem_ready = 1'b1;
      end
    join
    wait_empty();

    // Test 4: forwarding picks the youngest of two stores to the same word.
    mem_ready = 1'b0;
    do_store(32'd84, 32'd3);
    do_store(32'd84, 32'd7);
    dataadr = 32'd84;
    #1;
    check("t4_hit84", {31'b0, fwd_hit}, 32'd1);
    check("t4_data84", fwd_data, 32'd7);
    dataadr = 32'd86;
    #1;
    check("t4_hit86", {31'b0, fwd_hit}, 32'd1);
    check("t4_data86", fwd_data, 32'd7);
    dataadr = 32'd88;
    #1;
    check("t4_hit88", {31'b0, fwd_hit}, 32'd0);
    check("t4_data88", fwd_data, 32'd0);
    tick();
    mem_ready = 1'b1;
    wait_empty();

    // Test 5: full buffer with a same-cycle dequeue still stalls; order kept across wrap.
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) do_store(32'h100 + 32'(4 * i) + 32'(i & 3), 32'hA0 + 32'(i));
    mem_ready = 1'b1;
    memwrite  = 1'b1;
    dataadr   = 32'h200;
    writedata = 32'hBEEF;
    #1;
    check("t5_stall_full", {31'b0, stall}, 32'd1);
    tick();
    check("t5_stall_after", {31'b0, stall}, 32'd0);
    tick();
    memwrite = 1'b0;
    do_store(32'h204, 32'hCAFE);
    wait_empty();

    // Test 6: reset in the middle of a cycle with three stores pending.
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) do_store(32'h40 + 32'(4 * i), 32'h11 * 32'(i + 1));
    tick();
    mem_ready = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    check("t6_valid_drop", {31'b0, mem_valid}, 32'd0);
    check("t6_empty", {31'b0, empty}, 32'd1);
    tick();
    reset = 1'b0;
    repeat (4) tick();
    check("t6_no_xfer", {31'b0, mem_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
